// File: rtl/regfile_reader.sv
// regfile_reader
//   Read-side controller for the register bank in the ALU datapath.
//   It serves single-register reads over a valid/ready handshake, or a sweep
//   that returns every register in address order. Each response beat stays
//   registered and stable until the consumer accepts it. A write to the bank
//   on the capture edge is forwarded into the response.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   bank_flat             live bank contents, reg i at [i*WIDTH +: WIDTH]
//   wr_sel, wr_data       write enables and data driven to the bank this cycle
//   req_valid/req_addr    single-read request, accepted when req_ready is high
//   req_ready             high only in IDLE with no sweep_start and no reset
//   sweep_start           pulse: return registers 0..NREGS-1
//   rsp_valid/addr/data   response beat, held until rsp_ready
//   rsp_last              final beat of a single read or sweep
//   rsp_ready             consumer accepts the beat
//   busy                  controller is not idle
module regfile_reader #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREGS*WIDTH-1:0] bank_flat,
    input  logic [NREGS-1:0]       wr_sel,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   req_valid,
    input  logic [AW-1:0]          req_addr,
    output logic                   req_ready,
    input  logic                   sweep_start,
    output logic                   rsp_valid,
    output logic [AW-1:0]          rsp_addr,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_last,
    input  logic                   rsp_ready,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, RESP, SWEEP} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    state_t                        state;
    logic   [AW-1:0]               idx;
    logic   [AW-1:0]               nxt_idx;
    logic   [2**AW-1:0][WIDTH-1:0] cap;

    // Value each register holds after this edge: a same-cycle write wins over
    // the current bank contents. Unpopulated addresses read as zero.
    for (genvar i = 0; i < 2**AW; i++) begin : g_cap
        if (i < NREGS) begin : g_live
            assign cap[i] = wr_sel[i] ? wr_data : bank_flat[i*WIDTH +: WIDTH];
        end else begin : g_hole
            assign cap[i] = '0;
        end
    end

    assign nxt_idx   = idx + ONE;
    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) & ~sweep_start & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // sweep_start outranks a simultaneous request
                    if (sweep_start) begin
                        idx       <= '0;
                        rsp_addr  <= '0;
                        rsp_data  <= cap[0];
                        rsp_valid <= 1'b1;
                        rsp_last  <= (LAST_IDX == '0);
                        state     <= SWEEP;
                    end else if (req_valid && req_ready) begin
                        rsp_addr  <= req_addr;
                        rsp_data  <= cap[req_addr];
                        rsp_valid <= 1'b1;
                        rsp_last  <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                SWEEP: begin
                    if (rsp_ready) begin
                        if (idx == LAST_IDX) begin
                            rsp_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            // next beat is captured on the accepting edge so
                            // the stream has no bubble
                            idx      <= nxt_idx;
                            rsp_addr <= nxt_idx;
                            rsp_data <= cap[nxt_idx];
                            rsp_last <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_reader.sv
module tb_regfile_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bank_flat;
    logic [3:0]  wr_sel;
    logic [3:0]  wr_data;
    logic        req_valid;
    logic [1:0]  req_addr;
    logic        req_ready;
    logic        sweep_start;
    logic        rsp_valid;
    logic [1:0]  rsp_addr;
    logic [3:0]  rsp_data;
    logic        rsp_last;
    logic        rsp_ready;
    logic        busy;

    int total  = 0;
    int passed = 0;

    regfile_reader #(.WIDTH(4), .NREGS(4), .AW(2)) dut (
        .clk(clk), .reset(reset), .bank_flat(bank_flat), .wr_sel(wr_sel),
        .wr_data(wr_data), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .sweep_start(sweep_start), .rsp_valid(rsp_valid),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Register value visible after the capture edge: pending write wins.
    function automatic logic [3:0] model(input logic [15:0] bank, input logic [3:0] sel,
                                         input logic [3:0] wd, input int a);
        if (a >= 4) return 4'h0;
        return sel[a] ? wd : bank[a*4 +: 4];
    endfunction

    task automatic do_read(input logic [1:0] a, input logic [15:0] bank, input logic [3:0] sel,
                           input logic [3:0] wd, input int stall, input bit zero_stall);
        logic [3:0] exp;
        @(negedge clk);
        bank_flat = bank; wr_sel = sel; wr_data = wd;
        req_addr = a; req_valid = 1'b1; sweep_start = 1'b0; rsp_ready = 1'b0;
        #1 chk("rd_req_ready", req_ready, 1);
        exp = model(bank, sel, wd, a);
        @(posedge clk); #1;
        req_valid = 1'b0; wr_sel = 4'h0;
        chk("rd_valid", rsp_valid, 1);
        chk("rd_data", rsp_data, exp);
        chk("rd_addr", rsp_addr, a);
        chk("rd_last", rsp_last, 1);
        chk("rd_busy", busy, 1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (zero_stall) begin
                bank_flat = 16'h0000; wr_sel = 4'h0; req_valid = 1'b0; sweep_start = 1'b0;
            end else begin
                bank_flat = 16'($urandom); wr_sel = 4'($urandom); wr_data = 4'($urandom);
                req_valid = 1'($urandom); req_addr = 2'($urandom); sweep_start = 1'($urandom);
            end
            #1 chk("rd_stall_req_ready", req_ready, 0);
            @(posedge clk); #1;
            chk("rd_stall_valid", rsp_valid, 1);
            chk("rd_stall_data", rsp_data, exp);
            chk("rd_stall_addr", rsp_addr, a);
        end
        @(negedge clk);
        req_valid = 1'b0; sweep_start = 1'b0; wr_sel = 4'h0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rd_done_valid", rsp_valid, 0);
        chk("rd_done_busy", busy, 0);
        @(negedge clk); #1 chk("rd_idle_ready", req_ready, 1);
    endtask

    task automatic do_sweep(input logic [15:0] bank, input logic [3:0] sel, input logic [3:0] wd,
                            input bit also_req, input int stall_pct, input bit hold);
        logic [3:0] exp;
        int  beat;
        int  stalls;
        bit  done;
        @(negedge clk);
        bank_flat = bank; wr_sel = sel; wr_data = wd;
        sweep_start = 1'b1; req_valid = also_req; req_addr = 2'd3; rsp_ready = 1'b0;
        #1 chk("sw_req_ready", req_ready, 0);
        exp = model(bank, sel, wd, 0);
        beat = 0; stalls = 0; done = 1'b0;
        @(posedge clk); #1;
        sweep_start = 1'b0; req_valid = 1'b0; wr_sel = 4'h0;
        while (!done) begin
            chk("sw_valid", rsp_valid, 1);
            chk("sw_addr", rsp_addr, 32'(beat));
            chk("sw_data", rsp_data, exp);
            chk("sw_last", rsp_last, 32'(beat == 3));
            chk("sw_busy", busy, 1);
            @(negedge clk);
            rsp_ready = (stalls >= 3) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            if (!hold) begin
                bank_flat = 16'($urandom); wr_sel = 4'($urandom); wr_data = 4'($urandom);
                req_valid = 1'($urandom); req_addr = 2'($urandom); sweep_start = 1'($urandom);
            end
            #1 chk("sw_mid_req_ready", req_ready, 0);
            if (rsp_ready) begin
                if (beat == 3) done = 1'b1;
                else begin
                    exp = model(bank_flat, wr_sel, wr_data, beat + 1);
                    beat++;
                end
                stalls = 0;
            end else stalls++;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0; req_valid = 1'b0; sweep_start = 1'b0; wr_sel = 4'h0;
        chk("sw_done_valid", rsp_valid, 0);
        chk("sw_done_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b1; bank_flat = 16'h0; wr_sel = 4'h0; wr_data = 4'h0;
        req_valid = 1'b0; req_addr = 2'd0; sweep_start = 1'b0; rsp_ready = 1'b0;
        #2;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_addr", rsp_addr, 0);
        chk("rst_last", rsp_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        @(negedge clk) reset = 1'b0;

        // single read, then 5-cycle backpressure with the bank cleared
        do_read(2'd2, 16'hDCBA, 4'h0, 4'h0, 5, 1'b1);
        // same-cycle write forwarded into the response
        do_read(2'd1, 16'h00B0, 4'b0010, 4'h7, 0, 1'b0);
        // write to a different register is not forwarded
        do_read(2'd1, 16'h00B0, 4'b0100, 4'h7, 1, 1'b0);
        // full-speed sweep with a steady bank
        do_sweep(16'h9A5F, 4'h0, 4'h0, 1'b0, 0, 1'b1);
        // sweep_start together with req_valid: the sweep wins
        do_sweep(16'h1234, 4'h0, 4'h0, 1'b1, 0, 1'b1);

        // reset arriving mid-sweep, during the second beat
        @(negedge clk);
        bank_flat = 16'h9A5F; wr_sel = 4'h0; sweep_start = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        chk("ab_beat0", rsp_data, 4'hF);
        @(posedge clk); #1;
        chk("ab_beat1", rsp_data, 4'h5);
        chk("ab_beat1_addr", rsp_addr, 1);
        #2 reset = 1'b1;
        #1;
        chk("ab_valid", rsp_valid, 0);
        chk("ab_busy", busy, 0);
        chk("ab_data", rsp_data, 0);
        chk("ab_req_ready", req_ready, 0);
        @(posedge clk); #1;
        chk("ab_held_valid", rsp_valid, 0);
        @(negedge clk);
        reset = 1'b0; rsp_ready = 1'b0;
        do_read(2'd3, 16'h5A3C, 4'h0, 4'h0, 2, 1'b0);

        // randomized mix of reads and sweeps with random stalls and writes
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(2) == 0)
                do_sweep(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                         $urandom_range(60), 1'b0);
            else
                do_read(2'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
                        $urandom_range(3), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
